cr_fifo_rd_stage: RTL



---
 rtl/cr_fifo_rd_stage.sv | 117 +++++++++++
 1 files changed

// File: rtl/cr_fifo_rd_stage.sv
// cr_fifo_rd_stage: drains a show-ahead FIFO read port into a registered
// valid/ready stream through a 2-entry (head + skid) output buffer. The
// downstream ready never reaches fifo_ren, yet one beat per cycle is sustained.
module cr_fifo_rd_stage #(
  parameter int unsigned N_DATA_BITS = 64,
  parameter int unsigned N_CNT_BITS  = 16,
  parameter int unsigned DATA_RESET  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fifo_empty,
  input  logic [N_DATA_BITS-1:0] fifo_rdata,
  output logic                   fifo_ren,
  output logic                   o_valid,
  output logic [N_DATA_BITS-1:0] o_data,
  input  logic                   o_ready,
  input  logic                   flush,
  output logic [N_CNT_BITS-1:0]  pop_cnt,
  output logic [1:0]             buf_cnt
);

  localparam int unsigned BUF_W = 2;
  localparam logic [BUF_W-1:0] BUF_EMPTY = BUF_W'(0);
  localparam logic [BUF_W-1:0] BUF_ONE   = BUF_W'(1);
  localparam logic [BUF_W-1:0] BUF_FULL  = BUF_W'(2);

  logic [BUF_W-1:0]       buf_cnt_q, buf_cnt_d;
  logic                   valid_q,   valid_d;
  logic [N_DATA_BITS-1:0] head_q,    head_d;
  logic [N_DATA_BITS-1:0] skid_q,    skid_d;
  logic [N_CNT_BITS-1:0]  pop_cnt_q, pop_cnt_d;

  logic push;
  logic take;

  // Pop whenever the buffer has room; held off during reset and flush.
  always_comb begin
    push     = rst_n & ~fifo_empty & ~flush & (buf_cnt_q != BUF_FULL);
    fifo_ren = push;
    take     = valid_q & o_ready;
  end

  // Buffer next-state: head always holds the oldest beat, skid the younger.
  always_comb begin
    buf_cnt_d = buf_cnt_q;
    head_d    = head_q;
    skid_d    = skid_q;
    pop_cnt_d = pop_cnt_q + N_CNT_BITS'(push);

    if (flush) begin
      buf_cnt_d = BUF_EMPTY;
    end else begin
      case (buf_cnt_q)
        BUF_EMPTY: begin
          if (push) begin
            head_d    = fifo_rdata;
            buf_cnt_d = BUF_ONE;
          end
        end
        BUF_ONE: begin
          if (push && take) begin
            head_d    = fifo_rdata;
          end else if (push) begin
            skid_d    = fifo_rdata;
            buf_cnt_d = BUF_FULL;
          end else if (take) begin
            buf_cnt_d = BUF_EMPTY;
          end
        end
        BUF_FULL: begin
          if (take) begin
            head_d    = skid_q;
            buf_cnt_d = BUF_ONE;
          end
        end
        default: begin
          buf_cnt_d = BUF_EMPTY;
        end
      endcase
    end

    valid_d = (buf_cnt_d != BUF_EMPTY);
  end

  // Control state and pop counter, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_cnt_q <= BUF_EMPTY;
      valid_q   <= 1'b0;
      pop_cnt_q <= '0;
    end else begin
      buf_cnt_q <= buf_cnt_d;
      valid_q   <= valid_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

  // Data registers; cleared on reset only when DATA_RESET is set.
  always_ff @(posedge clk) begin
    if (!rst_n && (DATA_RESET != 0)) begin
      head_q <= '0;
      skid_q <= '0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  // Output mapping.
  always_comb begin
    o_valid = valid_q;
    o_data  = head_q;
    pop_cnt = pop_cnt_q;
    buf_cnt = buf_cnt_q;
  end

endmodule
